// File: rtl/ysyx_bus_pkg.sv
// ysyx_bus_pkg: state encoding and bus constants shared by the I/D bus arbiter
package ysyx_bus_pkg;
   typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B} bus_arb_state_t;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [7:0] STRB_FULL = 8'hFF;
endpackage

// File: rtl/ysyx_rr_arb2.sv
// ysyx_rr_arb2: two-way round-robin pick with a last-grant register (req[0]=I side, req[1]=D side)
module ysyx_rr_arb2
   import ysyx_bus_pkg::*;
#(
   parameter bit RR_INIT = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt
);
   logic last_q, last_d;
   // on a tie grant the side that did not win last time; remember whoever is taken
   always_comb begin
      gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
      last_d = (take && gnt != 2'b00) ? gnt[1] : last_q;
   end
   // last-grant register, 1 means the D side won most recently
   always_ff @(posedge clock) begin
      if (!reset) last_q <= RR_INIT;
      else last_q <= last_d;
   end
endmodule

// File: rtl/ysyx_bus_arb.sv
// ysyx_bus_arb: one-outstanding-transaction arbiter of L1I and L1D onto a single AXI4-Lite-style port
module ysyx_bus_arb
   import ysyx_bus_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter bit RR_INIT = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ifu_arvalid,
   input  logic [XLEN-1:0] ifu_araddr,
   input  logic            ifu_flush,
   output logic            ifu_bus_ready,
   output logic            ifu_rready,
   output logic [XLEN-1:0] ifu_rdata,
   input  logic            lsu_arvalid,
   input  logic [XLEN-1:0] lsu_araddr,
   input  logic [7:0]      lsu_rstrb,
   output logic            lsu_rvalid,
   output logic [XLEN-1:0] lsu_rdata,
   input  logic            lsu_awvalid,
   input  logic [XLEN-1:0] lsu_awaddr,
   input  logic            lsu_wvalid,
   input  logic [XLEN-1:0] lsu_wdata,
   input  logic [7:0]      lsu_wstrb,
   output logic            lsu_wready,
   output logic            mem_arvalid,
   input  logic            mem_arready,
   output logic [XLEN-1:0] mem_araddr,
   output logic [7:0]      mem_rstrb,
   input  logic            mem_rvalid,
   output logic            mem_rready,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [1:0]      mem_rresp,
   output logic            mem_awvalid,
   input  logic            mem_awready,
   output logic [XLEN-1:0] mem_awaddr,
   output logic            mem_wvalid,
   input  logic            mem_wready,
   output logic [XLEN-1:0] mem_wdata,
   output logic [7:0]      mem_wstrb,
   input  logic            mem_bvalid,
   output logic            mem_bready,
   input  logic [1:0]      mem_bresp,
   output logic            bus_err
);
   bus_arb_state_t state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [7:0] strb_q, strb_d;
   logic aw_done_q, aw_done_d, w_done_q, w_done_d, drop_q, drop_d;
   logic d_wr, d_req;
   logic [1:0] gnt;

   assign d_wr = lsu_awvalid & lsu_wvalid;
   assign d_req = d_wr | lsu_arvalid;

   ysyx_rr_arb2 #(.RR_INIT(RR_INIT)) u_rr (
      .clock (clock),
      .reset (reset),
      .req   ({d_req, ifu_arvalid}),
      .take  (state_q == IDLE),
      .gnt   (gnt)
   );

   // one register set serves whichever transaction is in flight
   assign mem_araddr = addr_q;
   assign mem_awaddr = addr_q;
   assign mem_rstrb  = strb_q;
   assign mem_wstrb  = strb_q;
   assign mem_wdata  = wdata_q;
   assign ifu_rdata  = mem_rdata;
   assign lsu_rdata  = mem_rdata;

   // next-state, capture on grant, and per-state channel/handshake outputs
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      strb_d = strb_q;
      aw_done_d = aw_done_q;
      w_done_d = w_done_q;
      ifu_bus_ready = 1'b0;
      ifu_rready = 1'b0;
      lsu_rvalid = 1'b0;
      lsu_wready = 1'b0;
      mem_arvalid = 1'b0;
      mem_rready = 1'b0;
      mem_awvalid = 1'b0;
      mem_wvalid = 1'b0;
      mem_bready = 1'b0;
      bus_err = 1'b0;
      unique case (state_q)
         IDLE: begin
            ifu_bus_ready = reset;
            aw_done_d = 1'b0;
            w_done_d = 1'b0;
            if (gnt[1]) begin
               state_d = d_wr ? D_W : D_AR;
               addr_d = d_wr ? lsu_awaddr : lsu_araddr;
               wdata_d = lsu_wdata;
               strb_d = d_wr ? lsu_wstrb : lsu_rstrb;
            end else if (gnt[0]) begin
               state_d = I_AR;
               addr_d = ifu_araddr;
               strb_d = STRB_FULL;
            end
         end
         I_AR, D_AR: begin
            mem_arvalid = 1'b1;
            if (mem_arready) state_d = (state_q == I_AR) ? I_R : D_R;
         end
         I_R, D_R: begin
            mem_rready = 1'b1;
            if (mem_rvalid) begin
               ifu_rready = (state_q == I_R) && !(drop_q || ifu_flush);
               lsu_rvalid = (state_q == D_R);
               bus_err = (mem_rresp != RESP_OKAY);
               state_d = IDLE;
            end
         end
         D_W: begin
            mem_awvalid = !aw_done_q;
            mem_wvalid = !w_done_q;
            aw_done_d = aw_done_q | mem_awready;
            w_done_d = w_done_q | mem_wready;
            if (aw_done_d && w_done_d) state_d = D_B;
         end
         D_B: begin
            mem_bready = 1'b1;
            if (mem_bvalid) begin
               lsu_wready = 1'b1;
               bus_err = (mem_bresp != RESP_OKAY);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      drop_d = (state_q inside {I_AR, I_R}) && (state_d inside {I_AR, I_R}) && (drop_q || ifu_flush);
   end

   // state and capture registers; reset abandons any downstream transaction
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q <= '0;
         wdata_q <= '0;
         strb_q <= '0;
         aw_done_q <= 1'b0;
         w_done_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         strb_q <= strb_d;
         aw_done_q <= aw_done_d;
         w_done_q <= w_done_d;
         drop_q <= drop_d;
      end
   end

   // requesters must hold their request until the completion pulse
   a_ifu_hold: assert property (@(posedge clock) disable iff (!reset)
      (state_q inside {I_AR, I_R}) && !drop_q && !ifu_flush |-> ifu_arvalid);
   a_lsu_rd_hold: assert property (@(posedge clock) disable iff (!reset)
      (state_q inside {D_AR, D_R}) |-> lsu_arvalid);
   a_lsu_wr_hold: assert property (@(posedge clock) disable iff (!reset)
      (state_q inside {D_W, D_B}) |-> lsu_awvalid && lsu_wvalid);
endmodule

// File: tb/tb_ysyx_bus_arb.sv
// tb_ysyx_bus_arb: directed tests with a transaction-level expectation queue checked every cycle
module tb_ysyx_bus_arb;
   localparam int K_I = 0, K_DR = 1, K_DW = 2;
   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  strb;
   } txn_t;

   logic clock = 1'b0, reset = 1'b0;
   logic ifu_arvalid = 1'b0, ifu_flush = 1'b0;
   logic [31:0] ifu_araddr = '0;
   logic lsu_arvalid = 1'b0, lsu_awvalid = 1'b0, lsu_wvalid = 1'b0;
   logic [31:0] lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
   logic [7:0] lsu_rstrb = '0, lsu_wstrb = '0;
   logic mem_arready = 1'b0, mem_rvalid = 1'b0, mem_awready = 1'b0, mem_wready = 1'b0, mem_bvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [1:0] mem_rresp = '0, mem_bresp = '0;
   logic ifu_bus_ready, ifu_rready, lsu_rvalid, lsu_wready, bus_err;
   logic [31:0] ifu_rdata, lsu_rdata, mem_araddr, mem_awaddr, mem_wdata;
   logic [7:0] mem_rstrb, mem_wstrb;
   logic mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready;

   always #5 clock = ~clock;

   ysyx_bus_arb #(.XLEN(32), .RR_INIT(1'b0)) dut (
      .clock(clock), .reset(reset),
      .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_flush(ifu_flush),
      .ifu_bus_ready(ifu_bus_ready), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
      .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_rstrb(lsu_rstrb),
      .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_wvalid(lsu_wvalid),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
      .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr), .mem_rstrb(mem_rstrb),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
      .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
      .bus_err(bus_err)
   );

   int total = 0, bad = 0;
   txn_t q[$];
   int done_log[$];
   int n_i = 0, n_drd = 0, n_dwr = 0, w_only = 0, err_rv = 0, err_n = 0;
   int seen_i = 0, seen_drd = 0, seen_dwr = 0;
   logic [31:0] last_ifu_rdata = '0;
   logic [7:0] last_rstrb = '0;
   bit drop = 1'b0, exp_last_d = 1'b0;
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [1:0] r_resp = '0, b_resp = '0;
   int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
   logic [31:0] ar_lat = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h1234_5678 : (a ^ 32'hA5A5_5A5A);
   endfunction

   function automatic txn_t mk(input int k, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
      txn_t t;
      t.kind = k;
      t.addr = a;
      t.data = d;
      t.strb = s;
      return t;
   endfunction

   // memory slave: each ready/valid appears after its programmed number of waiting cycles
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (mem_arvalid) ar_lat = mem_araddr;
         ar_c = mem_arvalid ? ar_c + 1 : 0;
         r_c = mem_rready ? r_c + 1 : 0;
         aw_c = mem_awvalid ? aw_c + 1 : 0;
         w_c = mem_wvalid ? w_c + 1 : 0;
         b_c = mem_bready ? b_c + 1 : 0;
         mem_arready = mem_arvalid && ar_c > ar_dly;
         mem_rvalid = mem_rready && r_c > r_dly;
         mem_rdata = rd_val(ar_lat);
         mem_rresp = mem_rvalid ? r_resp : 2'b00;
         mem_awready = mem_awvalid && aw_c > aw_dly;
         mem_wready = mem_wvalid && w_c > w_dly;
         mem_bvalid = mem_bready && b_c > b_dly;
         mem_bresp = mem_bvalid ? b_resp : 2'b00;
      end
   end

   task automatic compare_cycle();
      txn_t h;
      bit hv, rd_done, wr_done;
      h = mk(-1, '0, '0, '0);
      hv = q.size() > 0;
      if (hv) h = q[0];
      rd_done = mem_rvalid && mem_rready;
      wr_done = mem_bvalid && mem_bready;
      if (mem_arvalid) begin
         chk("ar_kind", h.kind == K_I || h.kind == K_DR, 1);
         chk("araddr", mem_araddr, h.addr);
         chk("rstrb", mem_rstrb, h.strb);
         last_rstrb = mem_rstrb;
      end
      if (mem_rready) chk("r_kind", h.kind == K_I || h.kind == K_DR, 1);
      if (mem_awvalid) begin
         chk("aw_kind", h.kind == K_DW, 1);
         chk("awaddr", mem_awaddr, h.addr);
      end
      if (mem_wvalid) begin
         chk("w_kind", h.kind == K_DW, 1);
         chk("wdata", mem_wdata, h.data);
         chk("wstrb", mem_wstrb, h.strb);
      end
      if (mem_wvalid && !mem_awvalid) w_only++;
      if (ifu_flush && h.kind == K_I && (mem_arvalid || mem_rready)) drop = 1'b1;
      chk("ifu_rready", ifu_rready, rd_done && h.kind == K_I && !drop);
      chk("lsu_rvalid", lsu_rvalid, rd_done && h.kind == K_DR);
      chk("lsu_wready", lsu_wready, wr_done && h.kind == K_DW);
      chk("bus_err", bus_err, (rd_done && mem_rresp != 2'b00) || (wr_done && mem_bresp != 2'b00));
      if (ifu_rready) begin
         chk("ifu_rdata", ifu_rdata, h.data);
         last_ifu_rdata = ifu_rdata;
         n_i++;
      end
      if (lsu_rvalid) begin
         chk("lsu_rdata", lsu_rdata, h.data);
         n_drd++;
      end
      if (lsu_wready) n_dwr++;
      if (bus_err) err_n++;
      if (lsu_rvalid && bus_err) err_rv++;
      if (rd_done || wr_done) begin
         chk("completion_expected", hv, 1);
         if (hv) begin
            done_log.push_back(h.kind);
            void'(q.pop_front());
         end
         drop = 1'b0;
      end
   endtask

   // single compare process: DUT outputs against the expectation queue, every cycle
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            q.delete();
            drop = 1'b0;
         end else compare_cycle();
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      if (n_i != seen_i) begin seen_i = n_i; ifu_arvalid = 1'b0; end
      if (n_drd != seen_drd) begin seen_drd = n_drd; lsu_arvalid = 1'b0; end
      if (n_dwr != seen_dwr) begin seen_dwr = n_dwr; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (!(q.size() == 0 && ifu_bus_ready) && n < 300) begin
         step();
         n++;
      end
      chk({name, "_drain"}, n < 300, 1);
   endtask

   // expected service order from the round-robin rule: a tie goes to the side not granted last
   task automatic expect_pair(input bit has_i, input txn_t ti, input bit has_d, input txn_t td);
      if (has_d && (!has_i || !exp_last_d)) begin
         q.push_back(td);
         if (has_i) q.push_back(ti);
         exp_last_d = !has_i;
      end else begin
         q.push_back(ti);
         if (has_d) q.push_back(td);
         exp_last_d = has_d;
      end
   endtask

   task automatic req_i(input logic [31:0] a);
      ifu_arvalid = 1'b1;
      ifu_araddr = a;
   endtask

   task automatic req_dr(input logic [31:0] a, input logic [7:0] s);
      lsu_arvalid = 1'b1;
      lsu_araddr = a;
      lsu_rstrb = s;
   endtask

   task automatic req_dw(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
      lsu_awvalid = 1'b1;
      lsu_wvalid = 1'b1;
      lsu_awaddr = a;
      lsu_wdata = d;
      lsu_wstrb = s;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ifu_arvalid = 1'b0;
      lsu_arvalid = 1'b0;
      lsu_awvalid = 1'b0;
      lsu_wvalid = 1'b0;
      ifu_flush = 1'b0;
      exp_last_d = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic tie_round(input logic [31:0] ia, input logic [31:0] da, input logic [7:0] ds, input string name);
      req_i(ia);
      req_dr(da, ds);
      expect_pair(1, mk(K_I, ia, rd_val(ia), 8'hFF), 1, mk(K_DR, da, rd_val(da), ds));
      wait_drain(name);
   endtask

   initial begin
      int base, base2, n;
      int ord[4];
      ord[0] = K_DR; ord[1] = K_I; ord[2] = K_DR; ord[3] = K_I;
      step();
      step();
      chk("rst_bus_ready", ifu_bus_ready, 0);
      chk("rst_outs", {mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready,
                       ifu_rready, lsu_rvalid, lsu_wready, bus_err}, 0);
      chk("rst_regs", {mem_araddr, mem_wdata}, 0);
      chk("rst_strb", {mem_rstrb, mem_wstrb}, 0);
      reset = 1'b1;
      step();
      chk("idle_bus_ready", ifu_bus_ready, 1);

      // single I read with slow memory
      ar_dly = 2; r_dly = 2;
      base = n_i;
      req_i(32'h8000_0000);
      expect_pair(1, mk(K_I, 32'h8000_0000, rd_val(32'h8000_0000), 8'hFF), 0, mk(K_DR, '0, '0, '0));
      chk("t1_no_same_cycle", mem_arvalid, 0);
      step();
      chk("t1_latency", mem_arvalid, 1);
      wait_drain("t1");
      chk("t1_pulses", n_i - base, 1);
      chk("t1_rdata", last_ifu_rdata, 32'h1234_5678);
      chk("t1_rstrb", last_rstrb, 8'hFF);

      // simultaneous I and D reads alternate, D first after reset
      do_reset();
      ar_dly = 0; r_dly = 1;
      base = done_log.size();
      tie_round(32'h8000_0100, 32'h200, 8'h0F, "t2a");
      tie_round(32'h8000_0104, 32'h204, 8'hF0, "t2b");
      chk("t2_count", done_log.size() - base, 4);
      for (int i = 0; i < 4; i++)
         if (base + i < done_log.size()) chk($sformatf("t2_order%0d", i), done_log[base + i], ord[i]);

      // write with AW accepted three cycles before W
      aw_dly = 0; w_dly = 3; b_dly = 1;
      base = w_only; base2 = n_dwr;
      req_dw(32'h10, 32'hDEAD_BEEF, 8'h0F);
      expect_pair(0, mk(K_I, '0, '0, '0), 1, mk(K_DW, 32'h10, 32'hDEAD_BEEF, 8'h0F));
      wait_drain("t3");
      chk("t3_w_only", w_only - base, 3);
      chk("t3_wready", n_dwr - base2, 1);

      // write and read together: write first
      w_dly = 0;
      base = done_log.size();
      req_dw(32'h20, 32'h0BAD_F00D, 8'hFF);
      req_dr(32'h24, 8'h3C);
      q.push_back(mk(K_DW, 32'h20, 32'h0BAD_F00D, 8'hFF));
      q.push_back(mk(K_DR, 32'h24, rd_val(32'h24), 8'h3C));
      exp_last_d = 1'b1;
      wait_drain("t4");
      chk("t4_count", done_log.size() - base, 2);
      if (done_log.size() >= base + 2) begin
         chk("t4_first", done_log[base], K_DW);
         chk("t4_second", done_log[base + 1], K_DR);
      end

      // flush during I_R suppresses the pulse; next read is normal
      ar_dly = 1; r_dly = 4;
      base = n_i;
      req_i(32'h8000_0200);
      expect_pair(1, mk(K_I, 32'h8000_0200, rd_val(32'h8000_0200), 8'hFF), 0, mk(K_DR, '0, '0, '0));
      n = 0;
      while (!mem_rready && n < 50) begin step(); n++; end
      chk("t5_reach_r", mem_rready, 1);
      ifu_flush = 1'b1;
      ifu_arvalid = 1'b0;
      step();
      ifu_flush = 1'b0;
      wait_drain("t5");
      chk("t5_no_pulse", n_i - base, 0);
      chk("t5_idle", ifu_bus_ready, 1);
      req_i(32'h8000_0000);
      expect_pair(1, mk(K_I, 32'h8000_0000, rd_val(32'h8000_0000), 8'hFF), 0, mk(K_DR, '0, '0, '0));
      wait_drain("t5b");
      chk("t5_next_pulse", n_i - base, 1);
      chk("t5_next_rdata", last_ifu_rdata, 32'h1234_5678);

      // error responses still complete, with bus_err alongside
      ar_dly = 0; r_dly = 0; r_resp = 2'b10; b_resp = 2'b11;
      base = err_rv; base2 = err_n;
      req_dr(32'h300, 8'hFF);
      expect_pair(0, mk(K_I, '0, '0, '0), 1, mk(K_DR, 32'h300, rd_val(32'h300), 8'hFF));
      wait_drain("t6r");
      req_dw(32'h304, 32'h5555_AAAA, 8'hC3);
      expect_pair(0, mk(K_I, '0, '0, '0), 1, mk(K_DW, 32'h304, 32'h5555_AAAA, 8'hC3));
      wait_drain("t6w");
      chk("t6_err_with_rvalid", err_rv - base, 1);
      chk("t6_err_total", err_n - base2, 2);
      r_resp = 2'b00; b_resp = 2'b00;

      // reset while waiting in D_B
      b_dly = 10;
      base = n_dwr;
      req_dw(32'h40, 32'h1111_2222, 8'h03);
      expect_pair(0, mk(K_I, '0, '0, '0), 1, mk(K_DW, 32'h40, 32'h1111_2222, 8'h03));
      n = 0;
      while (!mem_bready && n < 50) begin step(); n++; end
      chk("t7_reach_b", mem_bready, 1);
      step();
      reset = 1'b0;
      lsu_awvalid = 1'b0;
      lsu_wvalid = 1'b0;
      exp_last_d = 1'b0;
      step();
      chk("t7_outs", {mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready,
                      ifu_rready, lsu_rvalid, lsu_wready, bus_err, ifu_bus_ready}, 0);
      chk("t7_regs", {mem_awaddr, mem_wdata}, 0);
      reset = 1'b1;
      step();
      chk("t7_idle", ifu_bus_ready, 1);
      chk("t7_no_wready", n_dwr - base, 0);

      // last-grant restored by reset: D wins the first tie again
      b_dly = 0;
      base = done_log.size();
      tie_round(32'h8000_0300, 32'h400, 8'h11, "t8");
      if (done_log.size() > base) chk("t8_first", done_log[base], K_DR);
      else chk("t8_done", done_log.size() - base, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
